mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage data-bus sequencer for the pipelined MIPS core. It drives the dbus request for the instruction currently in M, holds the request stable until `addr_ok`, and waits for `data_ok`. It captures load data and raises `stall_mem`, which the hazard unit ORs into the global stall. It also counts memory-wait cycles for performance reporting.

## Interface
Parameters
- `CNT_W`, default 32: width of the wait-cycle counter.

Ports
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `mem_en`  in  1: M-stage instruction is a load or store. Held stable by the pipeline while stalled.
- `mem_wr`  in  1: 1 = store, 0 = load.
- `mem_addr`  in  32: byte address.
- `mem_size`  in  3: access size code (0 = byte, 1 = half, 2 = word).
- `mem_strobe`  in  4: byte write enables for stores; ignored for loads.
- `mem_wdata`  in  32: store data.
- `pipe_go`  in  1: no stall source other than this block is active this cycle.
- `dreq_valid`  out  1: dbus request valid.
- `dreq_addr`  out  32: dbus address.
- `dreq_size`  out  3: dbus size.
- `dreq_strobe`  out  4: equals `mem_strobe` if `mem_wr`, else 4'b0.
- `dreq_data`  out  32: store data.
- `dresp_addr_ok`  in  1: request accepted.
- `dresp_data_ok`  in  1: data phase complete.
- `dresp_data`  in  32: load data, valid with `data_ok`.
- `rdata`  out  32: captured load data for the M/W register.
- `stall_mem`  out  1: M stage is waiting on memory.
- `wait_cycles`  out  `CNT_W`: count of cycles with `stall_mem`=1.

## Operation
The state machine has three states: IDLE, WAIT_DATA and DONE.

IDLE
- `dreq_valid` = `mem_en`.
- `dreq_addr/size/data/strobe` are driven combinationally from the `mem_*` inputs.
- Transitions:
  - `mem_en & addr_ok & data_ok` → DONE; capture `rdata <= dresp_data`.
  - `mem_en & addr_ok & ~data_ok` → WAIT_DATA.
  - `mem_en & ~addr_ok` → stay in IDLE with the request held.
  - `~mem_en` → stay in IDLE; `addr_ok` and `data_ok` are ignored.

WAIT_DATA
- `dreq_valid` = 0. Exactly one request is outstanding.
- `data_ok` → DONE; capture `rdata`. Stores also pass through DONE and still capture `rdata`, but its value is unused.
- Otherwise stay in WAIT_DATA.

DONE
- `dreq_valid` = 0; `rdata` held.
- `pipe_go` → IDLE, because the instruction leaves M this edge.
- `~pipe_go` → stay in DONE. No re-issue while other units stall.

Outputs and counter
- `stall_mem` = `mem_en & (state != DONE)`.
- `wait_cycles` increments by 1 on every edge where `stall_mem`=1. It wraps modulo 2^`CNT_W`.
- `dreq_size` and `dreq_data` are don't-care when `dreq_valid`=0, but must not change while `dreq_valid`=1 and `addr_ok` is 0.

## Timing
- Reset values: state = IDLE, `rdata` = 0, `wait_cycles` = 0.
- While `reset`=1: `dreq_valid` = 0 and `stall_mem` = 0.
- Minimum memory-op latency is 1 stall cycle: request cycle with `addr_ok` and `data_ok` both 1, then DONE, with the instruction advancing at the DONE edge if `pipe_go`.
- Load with `addr_ok` at cycle k and `data_ok` at cycle k+n:
  - `stall_mem` is high for cycles 0..k+n.
  - DONE at k+n+1.
  - `rdata` valid from k+n+1.
- Back-to-back memory ops: the next request is presented the cycle after DONE→IDLE, never in DONE.
- Reset asserted mid-transaction returns to IDLE immediately. Any later `data_ok` arriving while in IDLE is ignored.
- `data_ok` in IDLE without `addr_ok`, or with `mem_en`=0, is ignored and causes no state change.

## Test plan
- **Load, zero-wait.** Stimulus: `mem_en`=1, `mem_wr`=0, addr 0x80000010; bus asserts `addr_ok` and `data_ok` in the same cycle with data 0xDEADBEEF; `pipe_go`=1.
  - Required: `stall_mem` high for exactly 1 cycle, then low.
  - Required: `rdata`=0xDEADBEEF in DONE; state IDLE next cycle.
  - Required: `wait_cycles`=1.
- **Load, split phases.** Stimulus: `addr_ok` at cycle 2, `data_ok` at cycle 5, data 0x12345678.
  - Required: `dreq_valid` high for cycles 0–2 with addr stable, then low for cycles 3–5.
  - Required: `stall_mem` high for cycles 0–5; `rdata`=0x12345678 at cycle 6.
  - Required: `wait_cycles`=6.
- **Store strobe.** Stimulus: `mem_wr`=1, strobe 4'b0011, wdata 0x0000ABCD.
  - Required: `dreq_strobe`=4'b0011 and `dreq_data`=0x0000ABCD while valid.
  - Required: for a load with `mem_strobe`=4'b1111 presented, `dreq_strobe`=4'b0000.
- **External stall holds DONE.** Stimulus: complete a load with `pipe_go`=0 for 3 cycles, then 1.
  - Required: state stays DONE; `dreq_valid`=0; `stall_mem`=0; `rdata` unchanged for those 3 cycles.
  - Required: no second request is issued.
- **Reset mid-op.** Stimulus: assert `reset` during WAIT_DATA, release it, then pulse `data_ok` with `mem_en`=0.
  - Required: state is IDLE, `rdata`=0, `wait_cycles`=0, `dreq_valid`=0.
  - Required: the stray `data_ok` is ignored.
- **Counter wrap.** Stimulus: `CNT_W`=4; hold a request for 17 cycles with `addr_ok`=0.
  - Required: `wait_cycles` reads 1 (17 mod 16).

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage data-bus sequencer: issues the M-stage dbus request, waits for the
// address and data phases, captures load data, and counts memory-stall cycles.
module mem_stage_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_en,
  input  logic             mem_wr,
  input  logic [31:0]      mem_addr,
  input  logic [2:0]       mem_size,
  input  logic [3:0]       mem_strobe,
  input  logic [31:0]      mem_wdata,
  input  logic             pipe_go,
  output logic             dreq_valid,
  output logic [31:0]      dreq_addr,
  output logic [2:0]       dreq_size,
  output logic [3:0]       dreq_strobe,
  output logic [31:0]      dreq_data,
  input  logic             dresp_addr_ok,
  input  logic             dresp_data_ok,
  input  logic [31:0]      dresp_data,
  output logic [31:0]      rdata,
  output logic             stall_mem,
  output logic [CNT_W-1:0] wait_cycles
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DATA = 2'd1;
  localparam logic [1:0] DONE      = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             capture;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        // Bus handshakes are meaningless unless a request is actually presented.
        if (mem_en && dresp_addr_ok) begin
          if (dresp_data_ok) begin
            state_d = DONE;
            capture = 1'b1;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (dresp_data_ok) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      DONE: begin
        if (pipe_go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) rdata_q <= dresp_data;
      if (stall_mem) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Request fields follow the M-stage inputs, which the pipeline holds while stalled.
  assign dreq_valid  = ~reset & mem_en & (state_q == IDLE);
  assign dreq_addr   = mem_addr;
  assign dreq_size   = mem_size;
  assign dreq_strobe = mem_wr ? mem_strobe : 4'b0000;
  assign dreq_data   = mem_wdata;

  assign stall_mem   = ~reset & mem_en & (state_q != DONE);
  assign rdata       = rdata_q;
  assign wait_cycles = cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: scoreboarded load data plus per-cycle bus checks.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en, mem_wr, pipe_go;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic [3:0]  mem_strobe;
  logic        addr_ok, data_ok;
  logic [31:0] dresp_data;

  logic        dreq_valid, stall_mem;
  logic [31:0] dreq_addr, dreq_data, rdata;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] wait_cycles;

  logic        dreq_valid4, stall_mem4;
  logic [31:0] dreq_addr4, dreq_data4, rdata4;
  logic [2:0]  dreq_size4;
  logic [3:0]  dreq_strobe4;
  logic [3:0]  wait_cycles4;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_strobe(mem_strobe), .mem_wdata(mem_wdata), .pipe_go(pipe_go),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(addr_ok),
    .dresp_data_ok(data_ok), .dresp_data(dresp_data), .rdata(rdata),
    .stall_mem(stall_mem), .wait_cycles(wait_cycles)
  );

  mem_stage_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_strobe(mem_strobe), .mem_wdata(mem_wdata), .pipe_go(pipe_go),
    .dreq_valid(dreq_valid4), .dreq_addr(dreq_addr4), .dreq_size(dreq_size4),
    .dreq_strobe(dreq_strobe4), .dreq_data(dreq_data4), .dresp_addr_ok(addr_ok),
    .dresp_data_ok(data_ok), .dresp_data(dresp_data), .rdata(rdata4),
    .stall_mem(stall_mem4), .wait_cycles(wait_cycles4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_en = 0; mem_wr = 0; mem_addr = 0; mem_size = 3'd2; mem_strobe = 0;
    mem_wdata = 0; pipe_go = 1; addr_ok = 0; data_ok = 0; dresp_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic pop_rdata(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      check(tag, rdata, exp_q.pop_front());
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    #1;
    check("rst_valid", {31'd0, dreq_valid}, 32'd0);
    check("rst_stall", {31'd0, stall_mem}, 32'd0);
    do_reset();
    check("rst_rdata", rdata, 32'h0);
    check("rst_wait", wait_cycles, 32'd0);

    // Load, zero-wait
    mem_en = 1; mem_addr = 32'h8000_0010; mem_strobe = 4'b1111;
    addr_ok = 1; data_ok = 1; dresp_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    check("zw_c0_stall", {31'd0, stall_mem}, 32'd1);
    check("zw_c0_valid", {31'd0, dreq_valid}, 32'd1);
    check("zw_c0_strobe_load", {28'd0, dreq_strobe}, 32'd0);
    tick();
    addr_ok = 0; data_ok = 0; dresp_data = 32'h0;
    #1;
    check("zw_c1_stall", {31'd0, stall_mem}, 32'd0);
    check("zw_c1_valid", {31'd0, dreq_valid}, 32'd0);
    pop_rdata("zw_rdata");
    check("zw_wait", wait_cycles, 32'd1);
    tick();
    mem_en = 0;
    #1;
    check("zw_c2_stall", {31'd0, stall_mem}, 32'd0);
    mem_en = 1;
    #1;
    check("zw_idle_again", {31'd0, dreq_valid}, 32'd1);
    mem_en = 0;

    // Load, split phases: addr_ok at cycle 2, data_ok at cycle 5
    do_reset();
    mem_en = 1; mem_addr = 32'h0000_1234;
    for (int c = 0; c <= 5; c++) begin
      addr_ok = (c == 2);
      data_ok = (c == 5);
      dresp_data = (c == 5) ? 32'h1234_5678 : 32'hBAD0_0000;
      if (c == 5) exp_q.push_back(32'h1234_5678);
      #1;
      check($sformatf("sp_c%0d_valid", c), {31'd0, dreq_valid}, (c <= 2) ? 32'd1 : 32'd0);
      check($sformatf("sp_c%0d_stall", c), {31'd0, stall_mem}, 32'd1);
      if (c <= 2) check($sformatf("sp_c%0d_addr", c), dreq_addr, 32'h0000_1234);
      tick();
    end
    addr_ok = 0; data_ok = 0;
    #1;
    pop_rdata("sp_rdata");
    check("sp_c6_stall", {31'd0, stall_mem}, 32'd0);
    check("sp_wait", wait_cycles, 32'd6);
    tick();
    mem_en = 0;

    // Store strobe, then load with full strobe presented
    do_reset();
    mem_en = 1; mem_wr = 1; mem_strobe = 4'b0011; mem_wdata = 32'h0000_ABCD;
    addr_ok = 1;
    #1;
    check("st_valid", {31'd0, dreq_valid}, 32'd1);
    check("st_strobe", {28'd0, dreq_strobe}, 32'h3);
    check("st_data", dreq_data, 32'h0000_ABCD);
    tick();
    addr_ok = 0; data_ok = 1;
    #1;
    check("st_wait_valid", {31'd0, dreq_valid}, 32'd0);
    tick();
    data_ok = 0;
    #1;
    check("st_done_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    mem_wr = 0; mem_strobe = 4'b1111;
    #1;
    check("ld_strobe_zero", {28'd0, dreq_strobe}, 32'h0);
    check("ld_valid", {31'd0, dreq_valid}, 32'd1);
    mem_en = 0;

    // External stall holds DONE
    do_reset();
    mem_en = 1; pipe_go = 0; addr_ok = 1; data_ok = 1; dresp_data = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    dresp_data = 32'h5555_AAAA;
    #1;
    pop_rdata("xs_rdata");
    held = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("xs_c%0d_valid", c), {31'd0, dreq_valid}, 32'd0);
      check($sformatf("xs_c%0d_stall", c), {31'd0, stall_mem}, 32'd0);
      check($sformatf("xs_c%0d_rdata", c), rdata, held);
      tick();
    end
    check("xs_wait", wait_cycles, 32'd1);
    pipe_go = 1;
    tick();
    mem_en = 0; addr_ok = 0; data_ok = 0;
    #1;
    check("xs_after_rdata", rdata, held);

    // Reset mid-op during WAIT_DATA, then a stray data_ok
    do_reset();
    mem_en = 1; addr_ok = 1;
    tick();
    addr_ok = 0;
    tick();
    reset = 1;
    #1;
    check("rm_rst_valid", {31'd0, dreq_valid}, 32'd0);
    check("rm_rst_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    reset = 0; mem_en = 0;
    #1;
    check("rm_rdata", rdata, 32'h0);
    check("rm_wait", wait_cycles, 32'd0);
    check("rm_valid", {31'd0, dreq_valid}, 32'd0);
    data_ok = 1; dresp_data = 32'hFFFF_FFFF;
    tick();
    data_ok = 0;
    #1;
    check("rm_stray_rdata", rdata, 32'h0);
    mem_en = 1;
    #1;
    check("rm_stray_idle", {31'd0, dreq_valid}, 32'd1);
    check("rm_stray_stall", {31'd0, stall_mem}, 32'd1);
    mem_en = 0;

    // Counter wrap on the 4-bit instance
    do_reset();
    mem_en = 1;
    for (int c = 0; c < 17; c++) tick();
    mem_en = 0;
    #1;
    check("wrap_w4", {28'd0, wait_cycles4}, 32'd1);
    check("wrap_w32", wait_cycles, 32'd17);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
